// File: rtl/log_seq_ctrl.sv
// Capture/readout sequencer for the BRAM transmit-data logger: arms a capture,
// waits for memory-full, then streams a programmable address window out on valid/ready.
module log_seq_ctrl #(
    parameter int RAM_WIDTH = 18,
    parameter int RAM_DEPTH = 1024,
    parameter int ADDR_W    = 10,
    parameter int RD_LAT    = 2,
    parameter int TIMEOUT   = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic                 i_dump,
    input  logic                 i_abort,
    input  logic [ADDR_W-1:0]    i_rd_base,
    input  logic [ADDR_W:0]      i_rd_count,
    input  logic                 i_mem_full,
    input  logic [RAM_WIDTH-1:0] i_data_log_from_mem,
    input  logic                 i_ready,
    output logic                 o_run_log,
    output logic                 o_read_log,
    output logic [ADDR_W-1:0]    o_addr_log_to_mem,
    output logic [RAM_WIDTH-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error
);

    localparam int TO_W  = $clog2(TIMEOUT);
    localparam int LAT_W = $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_CAPTURE,
        S_FULL,
        S_RD_ADDR,
        S_RD_WAIT,
        S_OUT,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remaining;
    logic [TO_W-1:0]   to_cnt;
    logic [LAT_W-1:0]  lat_cnt;

    logic ld_window, to_clr, to_inc, lat_clr, lat_inc;
    logic cap_data, xfer, set_err, clr_err;

    assign o_addr_log_to_mem = addr;

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        o_run_log  = 1'b0;
        o_read_log = 1'b0;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        ld_window  = 1'b0;
        to_clr     = 1'b0;
        to_inc     = 1'b0;
        lat_clr    = 1'b0;
        lat_inc    = 1'b0;
        cap_data   = 1'b0;
        xfer       = 1'b0;
        set_err    = 1'b0;
        clr_err    = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (i_start) begin
                    clr_err  = 1'b1;
                    state_nx = S_ARM;
                end
            end
            S_ARM: begin
                o_run_log = 1'b1;
                o_busy    = 1'b1;
                to_clr    = 1'b1;
                state_nx  = S_CAPTURE;
            end
            S_CAPTURE: begin
                o_busy = 1'b1;
                if (i_mem_full) begin
                    state_nx = S_FULL;
                end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                    set_err  = 1'b1;
                    state_nx = S_IDLE;
                end else begin
                    to_inc = 1'b1;
                end
            end
            S_FULL: begin
                if (i_start) begin
                    clr_err  = 1'b1;
                    state_nx = S_ARM;
                end else if (i_dump) begin
                    ld_window = 1'b1;
                    state_nx  = S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                o_busy     = 1'b1;
                o_read_log = 1'b1;
                lat_clr    = 1'b1;
                state_nx   = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                o_busy     = 1'b1;
                o_read_log = 1'b1;
                if (lat_cnt == LAT_W'(RD_LAT - 1)) begin
                    cap_data = 1'b1;
                    state_nx = S_OUT;
                end else begin
                    lat_inc = 1'b1;
                end
            end
            S_OUT: begin
                o_busy     = 1'b1;
                o_read_log = 1'b1;
                if (i_ready) begin
                    xfer     = 1'b1;
                    state_nx = (remaining == (ADDR_W+1)'(1)) ? S_DONE : S_RD_ADDR;
                end
            end
            S_DONE: begin
                o_busy   = 1'b1;
                o_done   = 1'b1;
                state_nx = S_FULL;
            end
            default: state_nx = S_IDLE;
        endcase

        // Abort overrides every side effect of the current state, including a timeout error.
        if (i_abort) begin
            state_nx  = S_IDLE;
            ld_window = 1'b0;
            to_clr    = 1'b0;
            to_inc    = 1'b0;
            lat_clr   = 1'b0;
            lat_inc   = 1'b0;
            cap_data  = 1'b0;
            xfer      = 1'b0;
            set_err   = 1'b0;
            clr_err   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr      <= '0;
            remaining <= '0;
            to_cnt    <= '0;
            lat_cnt   <= '0;
            o_data    <= '0;
            o_valid   <= 1'b0;
            o_error   <= 1'b0;
        end else begin
            if (to_clr)      to_cnt <= '0;
            else if (to_inc) to_cnt <= to_cnt + TO_W'(1);

            if (lat_clr)      lat_cnt <= '0;
            else if (lat_inc) lat_cnt <= lat_cnt + LAT_W'(1);

            // RAM_DEPTH is a power of two, so the address wraps naturally.
            if (ld_window) begin
                addr      <= i_rd_base;
                remaining <= (i_rd_count == '0) ? (ADDR_W+1)'(RAM_DEPTH) : i_rd_count;
            end else if (xfer) begin
                addr      <= addr + ADDR_W'(1);
                remaining <= remaining - (ADDR_W+1)'(1);
            end

            if (cap_data) o_data <= i_data_log_from_mem;

            if (i_abort)       o_valid <= 1'b0;
            else if (cap_data) o_valid <= 1'b1;
            else if (xfer)     o_valid <= 1'b0;

            if (set_err)      o_error <= 1'b1;
            else if (clr_err) o_error <= 1'b0;
        end
    end

endmodule

// File: tb/tb_log_seq_ctrl.sv
// Bench for log_seq_ctrl: a word-order scoreboard plus per-cycle protocol checks,
// driven by directed capture/dump/abort/timeout/reset scenarios.
module tb_log_seq_ctrl;

    localparam int RAM_WIDTH = 18;
    localparam int RAM_DEPTH = 1024;
    localparam int ADDR_W    = 10;
    localparam int RD_LAT    = 2;
    localparam int TIMEOUT   = 4096;
    localparam int WORD_CYC  = RD_LAT + 2;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 i_start = 1'b0;
    logic                 i_dump = 1'b0;
    logic                 i_abort = 1'b0;
    logic [ADDR_W-1:0]    i_rd_base = '0;
    logic [ADDR_W:0]      i_rd_count = '0;
    logic                 i_mem_full = 1'b0;
    logic [RAM_WIDTH-1:0] i_data_log_from_mem;
    logic                 i_ready = 1'b1;
    logic                 o_run_log, o_read_log, o_valid, o_busy, o_done, o_error;
    logic [ADDR_W-1:0]    o_addr_log_to_mem;
    logic [RAM_WIDTH-1:0] o_data;

    always #5 clk = ~clk;

    log_seq_ctrl #(
        .RAM_WIDTH(RAM_WIDTH),
        .RAM_DEPTH(RAM_DEPTH),
        .ADDR_W(ADDR_W),
        .RD_LAT(RD_LAT),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_start(i_start),
        .i_dump(i_dump),
        .i_abort(i_abort),
        .i_rd_base(i_rd_base),
        .i_rd_count(i_rd_count),
        .i_mem_full(i_mem_full),
        .i_data_log_from_mem(i_data_log_from_mem),
        .i_ready(i_ready),
        .o_run_log(o_run_log),
        .o_read_log(o_read_log),
        .o_addr_log_to_mem(o_addr_log_to_mem),
        .o_data(o_data),
        .o_valid(o_valid),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_error(o_error)
    );

    // Logger BRAM stand-in: word at address a holds a, delivered RD_LAT enabled cycles later.
    logic [ADDR_W-1:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        if (o_read_log) begin
            rd_pipe[0] <= o_addr_log_to_mem;
            for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
        end
    end
    assign i_data_log_from_mem = RAM_WIDTH'(rd_pipe[RD_LAT-1]);

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int exp_q[$];
    bit done_due = 0;
    bit stall_prev = 0;
    int held_data = 0;
    int words = 0;
    int last_word = -1;
    int first_cyc = -1;
    int last_xfer_cyc = -1;
    int stalls = 0;
    bit thru_chk = 0;
    int run_cnt = 0;
    int done_cnt = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle protocol checker against the scoreboard of expected words.
    always @(negedge clk) begin
        if (o_run_log) run_cnt++;
        if (o_done)    done_cnt++;
        if (reset) begin
            if (stall_prev) begin
                chk("hold_valid", int'(o_valid), 1);
                chk("hold_data", int'(o_data), held_data);
            end
            chk("done_pulse", int'(o_done), int'(done_due));
            if (o_valid) begin
                chk("valid_implies_read", int'(o_read_log), 1);
                chk("valid_implies_busy", int'(o_busy), 1);
            end
            done_due = 0;
            if (o_valid && i_ready && !i_abort) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", int'(o_data), -1);
                end else begin
                    chk("word", int'(o_data), exp_q.pop_front());
                    if (exp_q.size() == 0) done_due = 1;
                end
                if (thru_chk && last_xfer_cyc >= 0)
                    chk("word_spacing", cyc - last_xfer_cyc, WORD_CYC);
                if (words == 0) first_cyc = cyc;
                words++;
                last_word     = int'(o_data);
                last_xfer_cyc = cyc;
            end
            if (o_valid && !i_ready && !i_abort) stalls++;
            stall_prev = o_valid && !i_ready && !i_abort;
            held_data  = int'(o_data);
        end else begin
            stall_prev = 0;
            done_due   = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int dump_cyc = 0;

    task automatic issue_dump(input int base, input int count);
        int n;
        n = (count == 0) ? RAM_DEPTH : count;
        for (int k = 0; k < n; k++) exp_q.push_back((base + k) % RAM_DEPTH);
        words         = 0;
        first_cyc     = -1;
        last_xfer_cyc = -1;
        dump_cyc      = cyc;
        i_rd_base     = ADDR_W'(base);
        i_rd_count    = (ADDR_W+1)'(count);
        i_dump        = 1'b1;
        tick();
        i_dump        = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cyc, input bit bp);
        bit got;
        got = 0;
        for (int k = 0; k < max_cyc && !got; k++) begin
            if (bp) i_ready = ($urandom_range(0, 99) < 30);
            tick();
            if (o_done) got = 1;
        end
        i_ready = 1'b1;
        chk({name, "_done_seen"}, int'(got), 1);
        chk({name, "_words_left"}, exp_q.size(), 0);
        tick();
        chk({name, "_back_to_full"}, int'(o_busy), 0);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_run"}, int'(o_run_log), 0);
        chk({name, "_read"}, int'(o_read_log), 0);
        chk({name, "_addr"}, int'(o_addr_log_to_mem), 0);
        chk({name, "_data"}, int'(o_data), 0);
        chk({name, "_valid"}, int'(o_valid), 0);
        chk({name, "_busy"}, int'(o_busy), 0);
        chk({name, "_done"}, int'(o_done), 0);
        chk({name, "_error"}, int'(o_error), 0);
    endtask

    initial begin
        int c0, d0, r0;
        bit got;

        repeat (5) tick();
        chk_all_zero("reset");
        reset = 1'b1;
        tick();

        // Capture: memory fills 1024 cycles after the run pulse.
        r0 = run_cnt;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("arm_run", int'(o_run_log), 1);
        chk("arm_busy", int'(o_busy), 1);
        tick();
        chk("capture_run_low", int'(o_run_log), 0);
        chk("capture_busy", int'(o_busy), 1);
        repeat (1022) tick();
        i_mem_full = 1'b1;
        tick();
        chk("full_busy", int'(o_busy), 0);
        chk("full_error", int'(o_error), 0);
        chk("capture_run_pulses", run_cnt - r0, 1);

        // Window 31..33 with ready held high.
        thru_chk = 1;
        d0 = done_cnt;
        issue_dump(31, 3);
        wait_done("dump31", 40, 0);
        chk("dump31_words", words, 3);
        chk("dump31_last", last_word, 33);
        chk("dump31_first_latency", first_cyc - dump_cyc, RD_LAT + 2);
        chk("dump31_done_count", done_cnt - d0, 1);

        issue_dump(1022, 4);
        wait_done("wrap", 40, 0);
        chk("wrap_words", words, 4);
        chk("wrap_last", last_word, 1);

        issue_dump(1022, 0);
        wait_done("fullwin", RAM_DEPTH * WORD_CYC + 50, 0);
        chk("fullwin_words", words, 1024);
        chk("fullwin_last", last_word, 1021);

        // Backpressure at ~30% ready.
        thru_chk = 0;
        stalls   = 0;
        issue_dump(0, 16);
        wait_done("bp", 2000, 1);
        chk("bp_words", words, 16);
        chk("bp_last", last_word, 15);
        chk("bp_stalled", int'(stalls > 0), 1);

        // Start and dump together in FULL: re-arm wins, no read.
        r0 = run_cnt;
        i_mem_full = 1'b0;
        i_start = 1'b1;
        i_dump  = 1'b1;
        i_rd_base  = '0;
        i_rd_count = (ADDR_W+1)'(4);
        tick();
        i_start = 1'b0;
        i_dump  = 1'b0;
        chk("prio_run", int'(o_run_log), 1);
        chk("prio_read", int'(o_read_log), 0);
        tick();
        chk("prio_capture_busy", int'(o_busy), 1);
        chk("prio_capture_read", int'(o_read_log), 0);
        i_mem_full = 1'b1;
        tick();
        chk("prio_full", int'(o_busy), 0);
        chk("prio_run_pulses", run_cnt - r0, 1);

        // Abort while a word is held in OUT with ready low.
        i_ready = 1'b0;
        d0 = done_cnt;
        issue_dump(5, 2);
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (o_valid) got = 1;
            else tick();
        end
        chk("abort_valid_seen", int'(got), 1);
        chk("abort_word", int'(o_data), 5);
        tick();
        tick();
        exp_q.delete();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("abort_valid", int'(o_valid), 0);
        chk("abort_busy", int'(o_busy), 0);
        chk("abort_read", int'(o_read_log), 0);
        chk("abort_done", int'(o_done), 0);
        i_ready = 1'b1;
        i_rd_base  = '0;
        i_rd_count = (ADDR_W+1)'(1);
        i_dump = 1'b1;
        tick();
        i_dump = 1'b0;
        tick();
        chk("idle_dump_busy", int'(o_busy), 0);
        chk("idle_dump_read", int'(o_read_log), 0);
        chk("abort_no_done", done_cnt - d0, 0);

        // Capture timeout.
        i_mem_full = 1'b0;
        c0 = cyc;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        got = 0;
        for (int k = 0; k < TIMEOUT + 100 && !got; k++) begin
            tick();
            if (o_error) got = 1;
        end
        chk("timeout_seen", int'(got), 1);
        chk("timeout_cycles", cyc - c0, TIMEOUT + 2);
        chk("timeout_idle", int'(o_busy), 0);
        tick();
        chk("timeout_sticky", int'(o_error), 1);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("rearm_clears_error", int'(o_error), 0);
        chk("rearm_run", int'(o_run_log), 1);
        i_mem_full = 1'b1;
        tick();
        tick();
        chk("rearm_full", int'(o_busy), 0);

        // Reset in the middle of a full-window dump.
        issue_dump(0, 0);
        repeat (20) tick();
        exp_q.delete();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_all_zero("midreset");
        end
        reset = 1'b1;
        r0 = run_cnt;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (6) tick();
        chk("post_reset_run_pulses", run_cnt - r0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/log_seq_ctrl.md
Name: log_seq_ctrl

Overview:
- Sequencer for the BRAM transmit-data logger.
- Arms a capture by pulsing the logger's run input, then waits for the memory-full flag.
- On request, it walks a programmable address window, applying the fixed BRAM read latency to each access.
- Each read word is presented on a valid/ready stream, for example to a UART or host-readout path.

Parameters:
- RAM_WIDTH, 18, logger data word width.
- RAM_DEPTH, 1024, logger depth in words; must be a power of two.
- ADDR_W, 10, address width (log2 of RAM_DEPTH).
- RD_LAT, 2, cycles from address/read-enable presented to data valid at the BRAM output.
- TIMEOUT, 4096, maximum cycles spent in CAPTURE before an error is flagged.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- i_start  in  1  one-cycle request to arm a new capture.
- i_dump  in  1  one-cycle request to read out the window.
- i_abort  in  1  one-cycle request to return to IDLE from any state.
- i_rd_base  in  ADDR_W  first address of the readout window; sampled on accepted i_dump.
- i_rd_count  in  ADDR_W+1  number of words to read; 0 means RAM_DEPTH; sampled on accepted i_dump.
- i_mem_full  in  1  logger memory-full flag.
- i_data_log_from_mem  in  RAM_WIDTH  BRAM read data.
- i_ready  in  1  downstream ready.
- o_run_log  out  1  one-cycle start pulse to the logger.
- o_read_log  out  1  logger read enable.
- o_addr_log_to_mem  out  ADDR_W  logger read address.
- o_data  out  RAM_WIDTH  output word, registered.
- o_valid  out  1  o_data valid.
- o_busy  out  1  high in every state except IDLE and FULL.
- o_done  out  1  one-cycle pulse after the last word is accepted.
- o_error  out  1  sticky capture-timeout flag; cleared by reset or by an accepted i_start.

Behaviour:
- Reset values: state IDLE, all outputs 0, internal counters 0. Reset mid-operation aborts immediately without a done pulse.
- IDLE:
  - i_start goes to ARM.
  - i_dump is ignored.
  - If i_start and i_dump arrive in the same cycle, i_start wins.
- ARM: o_run_log=1 for exactly one cycle, then go to CAPTURE.
- CAPTURE:
  - The timeout counter increments every cycle.
  - i_mem_full=1 goes to FULL.
  - If the counter reaches TIMEOUT-1 without full, set o_error=1 and go to IDLE.
  - i_start and i_dump are ignored.
- FULL (capture complete):
  - i_dump latches the base address, the remaining count (0 maps to RAM_DEPTH) and addr=base, then goes to RD_ADDR.
  - i_start goes to ARM (re-arm).
  - If both arrive in the same cycle, i_start wins.
- RD_ADDR:
  - Drive o_addr_log_to_mem=addr.
  - Clear the latency counter and go to RD_WAIT.
- RD_WAIT:
  - Address held; wait RD_LAT cycles.
  - On the final cycle, register i_data_log_from_mem into o_data, set o_valid=1 and go to OUT.
- OUT:
  - Hold o_data and o_valid stable until i_ready=1.
  - Transfer occurs on the cycle o_valid&i_ready.
  - After a transfer, clear o_valid, increment addr modulo RAM_DEPTH (RAM_DEPTH-1 wraps to 0) and decrement the remaining count.
  - If remaining was 1, go to DONE; otherwise go to RD_ADDR.
- DONE: o_done=1 for one cycle, then return to FULL, so the window may be dumped again without recapture.
- o_read_log is high in RD_ADDR, RD_WAIT and OUT, and low elsewhere.
- i_abort:
  - Highest priority in every state except reset.
  - Next cycle: state IDLE; o_valid, o_read_log and o_run_log are 0; no o_done; o_error is unchanged.
- Words appear in address order with no duplication or skipping under any i_ready pattern.
- Throughput with i_ready held high: one word per RD_LAT+2 cycles.
- Inputs are sampled only in the states listed; at all other times they are ignored.

Test Plan:
- Reset held low 5 cycles during a dump -> every output 0 on the cycle after reset is sampled; the next i_start produces exactly one o_run_log pulse.
- Capture then dump: i_start; i_mem_full rises 1024 cycles later; logger holds data = address; i_dump with base=31, count=3, i_ready=1 -> o_data 31, 32, 33 in order, one o_done pulse, return to FULL.
- Wrap and full window:
  - base=1022, count=4 -> words 1022, 1023, 0, 1.
  - count=0 -> exactly 1024 words, the last being 1021 (for base=1022).
- Backpressure: i_ready toggled pseudo-randomly at 30% duty, base=0, count=16 -> o_data stable while o_valid=1 and i_ready=0; 16 unique words 0..15 received.
- Timeout: i_start with i_mem_full held 0 -> o_error=1 after 4096 CAPTURE cycles, state IDLE; the next i_start clears o_error.
- Priority and abort:
  - i_start and i_dump together in FULL -> re-arm, o_run_log pulse, no read.
  - i_abort during OUT with i_ready=0 -> o_valid low next cycle, no o_done, o_busy=0.
